// File: rtl/axi_multi_port_bridge_pkg.sv
// Shared AXI3 field widths, requester ID encodings and fixed transfer attributes.
// Pure declarations: no logic, no latency, no flow control.
package axi_multi_port_bridge_pkg;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int ID_W    = 4;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int RESP_W  = 2;

    localparam logic [ID_W-1:0]    ID_IFU     = 4'd0;
    localparam logic [ID_W-1:0]    ID_LSU     = 4'd1;
    localparam logic [SIZE_W-1:0]  SIZE_WORD  = 3'd2;
    localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;

    typedef enum logic {AR_IDLE, AR_HOLD} ar_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
    } ar_cmd_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_cmd_t;
endpackage

// File: rtl/axi_multi_port_bridge_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the current pointer; pointer moves
// to winner+1 only when the caller reports the grant was consumed (advance).
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] sel;
    logic          found;
    int            idx;

    always_comb begin
        gnt   = '0;
        win   = ptr;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            sel = PW'(idx);
            if (!found && req[sel]) begin
                gnt[sel] = 1'b1;
                win      = sel;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
        end
    end
endmodule

// File: rtl/axi_multi_port_bridge.sv
// Bridges NPORT read requesters and one single-beat writer onto an AXI3 master; AR is
// granted combinationally (0 cycles) and held on ~arready, responses routed by ID with 0 latency.
module axi_multi_port_bridge
    import axi_multi_port_bridge_pkg::*;
#(
    parameter int NPORT     = 2,
    parameter int MAX_OUTST = 4,
    parameter int MAX_LEN   = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [NPORT-1:0]      rd_req,
    input  logic [NPORT*32-1:0]   rd_addr,
    input  logic [NPORT*4-1:0]    rd_len,
    output logic [NPORT-1:0]      rd_addr_ok,
    output logic [31:0]           rd_data,
    output logic [NPORT-1:0]      rd_valid,
    output logic [NPORT-1:0]      rd_last,
    output logic [NPORT-1:0]      rd_err,
    input  logic                  wr_req,
    input  logic [31:0]           wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strb,
    output logic                  wr_addr_ok,
    output logic                  wr_ok,
    output logic                  wr_err,
    output logic                  err_unexp,
    output logic [ID_W-1:0]       arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [LEN_W-1:0]      arlen,
    output logic [SIZE_W-1:0]     arsize,
    output logic [BURST_W-1:0]    arburst,
    output logic [LOCK_W-1:0]     arlock,
    output logic [CACHE_W-1:0]    arcache,
    output logic [PROT_W-1:0]     arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_W-1:0]       rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [RESP_W-1:0]     rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ID_W-1:0]       awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [LEN_W-1:0]      awlen,
    output logic [SIZE_W-1:0]     awsize,
    output logic [BURST_W-1:0]    awburst,
    output logic [LOCK_W-1:0]     awlock,
    output logic [CACHE_W-1:0]    awcache,
    output logic [PROT_W-1:0]     awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ID_W-1:0]       wid,
    output logic [DATA_W-1:0]     wdata,
    output logic [STRB_W-1:0]     wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_W-1:0]       bid,
    input  logic [RESP_W-1:0]     bresp,
    input  logic                  bvalid,
    output logic                  bready
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW = $clog2(MAX_OUTST) + 1;

    ar_state_t      state, state_n;
    ar_cmd_t        hold_cmd, ar_cmd;
    logic [PW-1:0]  hold_port, ar_port;
    logic [31:0]    rd_addr_a [NPORT];
    logic [3:0]     rd_len_a  [NPORT];
    logic [CW-1:0]  rd_cnt    [NPORT];
    logic [NPORT-1:0] elig, arb_req, gnt, rd_inc, rd_dec;
    logic           ar_hs;

    logic [PW-1:0]  rid_idx;
    logic           rid_ok, r_hit;

    wr_cmd_t        wr_q;
    logic           aw_pend, w_pend, wr_start;
    logic [CW-1:0]  wr_cnt;
    logic           b_hit;

    assign rready  = 1'b1;
    assign bready  = 1'b1;
    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign awid    = ID_LSU;
    assign wid     = ID_LSU;
    assign awlen   = '0;
    assign awsize  = SIZE_WORD;
    assign awburst = BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign wlast   = 1'b1;

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            rd_addr_a[p] = rd_addr[p*32 +: 32];
            rd_len_a[p]  = rd_len[p*4 +: 4];
            elig[p]      = rd_req[p] && (rd_cnt[p] < CW'(MAX_OUTST));
        end
    end

    // While holding, present only the held port so the arbiter advances past the right winner.
    assign arb_req = (state == AR_HOLD) ? (NPORT'(1) << hold_port) : elig;

    rr_arbiter #(.N(NPORT)) u_arb (
        .clk     (aclk),
        .rst     (areset),
        .req     (arb_req),
        .advance (ar_hs),
        .gnt     (gnt)
    );

    always_comb begin
        ar_port = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (gnt[p]) ar_port = PW'(p);
        end
        ar_cmd.addr = rd_addr_a[ar_port];
        ar_cmd.len  = rd_len_a[ar_port];
        ar_cmd.id   = ID_W'(ar_port);
        if (state == AR_HOLD) ar_cmd = hold_cmd;
        arvalid    = !areset && (|gnt);
        ar_hs      = arvalid && arready;
        rd_addr_ok = ar_hs ? gnt : '0;
        state_n    = state;
        case (state)
            AR_IDLE: if (arvalid && !arready) state_n = AR_HOLD;
            AR_HOLD: if (arready)             state_n = AR_IDLE;
            default:                          state_n = AR_IDLE;
        endcase
    end

    assign arid   = ar_cmd.id;
    assign araddr = ar_cmd.addr;
    assign arlen  = ar_cmd.len;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= AR_IDLE;
            hold_cmd  <= '0;
            hold_port <= '0;
        end else begin
            state <= state_n;
            if (state == AR_IDLE && arvalid) begin
                hold_cmd  <= ar_cmd;
                hold_port <= ar_port;
            end
        end
    end

    // A beat is only delivered when its ID names a port that actually has reads in flight.
    always_comb begin
        rid_idx  = rid[PW-1:0];
        rid_ok   = int'(rid) < NPORT;
        r_hit    = !areset && rvalid && rid_ok && (rd_cnt[rid_idx] != '0);
        rd_data  = rdata;
        rd_valid = r_hit ? (NPORT'(1) << rid_idx) : '0;
        rd_last  = (r_hit && rlast) ? (NPORT'(1) << rid_idx) : '0;
        rd_err   = (r_hit && (|rresp)) ? (NPORT'(1) << rid_idx) : '0;
        for (int p = 0; p < NPORT; p++) begin
            rd_inc[p] = ar_hs && (ar_port == PW'(p));
            rd_dec[p] = r_hit && rlast && (rid_idx == PW'(p));
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int p = 0; p < NPORT; p++) rd_cnt[p] <= '0;
            err_unexp <= 1'b0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                rd_cnt[p] <= rd_cnt[p] + CW'(rd_inc[p]) - CW'(rd_dec[p]);
            end
            if (rvalid && !r_hit) err_unexp <= 1'b1;
        end
    end

    // AW and W launch together from wr_req and then complete independently.
    always_comb begin
        wr_start   = !areset && wr_req && !aw_pend && !w_pend && (wr_cnt < CW'(MAX_OUTST));
        awvalid    = aw_pend || wr_start;
        wvalid     = w_pend || wr_start;
        awaddr     = aw_pend ? wr_q.addr : wr_addr;
        wdata      = w_pend  ? wr_q.data : wr_data;
        wstrb      = w_pend  ? wr_q.strb : wr_strb;
        wr_addr_ok = (wr_start || aw_pend || w_pend)
                     && !(awvalid && !awready) && !(wvalid && !wready);
        b_hit      = !areset && bvalid && (bid == ID_LSU);
        wr_ok      = b_hit;
        wr_err     = b_hit && (|bresp);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            wr_q    <= '0;
            wr_cnt  <= '0;
        end else begin
            aw_pend <= awvalid && !awready;
            w_pend  <= wvalid && !wready;
            if (wr_start) begin
                wr_q.addr <= wr_addr;
                wr_q.data <= wr_data;
                wr_q.strb <= wr_strb;
            end
            wr_cnt <= wr_cnt + CW'(wr_addr_ok) - CW'(b_hit && (wr_cnt != '0));
        end
    end

    for (genvar g = 0; g < NPORT; g++) begin : g_len_chk
        a_len: assert property (@(posedge aclk) disable iff (areset)
            rd_req[g] |-> (int'(rd_len_a[g]) < MAX_LEN));
    end
    a_ifu_id: assert property (@(posedge aclk) disable iff (areset)
        rd_addr_ok[0] |-> (arid == ID_IFU));
endmodule

// File: tb/tb_axi_multi_port_bridge.sv
// Directed scenarios plus a randomized read run against a queue-based reference model.
module tb_axi_multi_port_bridge;
    localparam int NPORT = 2, MAX_OUTST = 4, MAX_LEN = 4;

    logic aclk, areset;
    logic [1:0] rd_req, rd_addr_ok, rd_valid, rd_last, rd_err;
    logic [63:0] rd_addr;
    logic [7:0] rd_len;
    logic [31:0] rd_data, wr_addr, wr_data;
    logic [3:0] wr_strb;
    logic wr_req, wr_addr_ok, wr_ok, wr_err, err_unexp;
    logic [3:0] arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0] arsize, arprot, awsize, awprot;
    logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_vec = 0, n_err = 0;

    axi_multi_port_bridge #(.NPORT(NPORT), .MAX_OUTST(MAX_OUTST), .MAX_LEN(MAX_LEN)) dut (
        .aclk(aclk), .areset(areset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_addr_ok(rd_addr_ok), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .rd_err(rd_err), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_addr_ok(wr_addr_ok), .wr_ok(wr_ok), .wr_err(wr_err), .err_unexp(err_unexp),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req = '0; rd_addr = '0; rd_len = '0; arready = 0;
        rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        wr_req = 0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    endtask

    task automatic do_reset();
        tick(); idle_inputs(); areset = 1;
        tick(); tick(); areset = 0;
    endtask

    task automatic send_rlast(input logic [3:0] id, input logic [1:0] exp_v);
        tick(); idle_inputs();
        rvalid = 1; rid = id; rlast = 1; rdata = $urandom;
        #2;
        n_vec++; if (rd_valid !== exp_v) begin n_err++; $display("FAIL drain_rd_valid id%0d: got %b want %b", id, rd_valid, exp_v); end
    endtask

    task automatic test_reset();
        tick();
        rd_req = 2'b11; wr_req = 1; arready = 1;
        #2;
        n_vec++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
        n_vec++; if ({awvalid, wvalid} !== 2'b00) begin n_err++; $display("FAIL rst_aw_w: got %b want 00", {awvalid, wvalid}); end
        n_vec++; if (rd_addr_ok !== 2'b00) begin n_err++; $display("FAIL rst_addr_ok: got %b want 00", rd_addr_ok); end
        n_vec++; if (err_unexp !== 1'b0) begin n_err++; $display("FAIL rst_err_unexp: got %b want 0", err_unexp); end
        n_vec++; if ({rready, bready} !== 2'b11) begin n_err++; $display("FAIL rst_readys: got %b want 11", {rready, bready}); end
        tick(); idle_inputs(); areset = 0;
    endtask

    task automatic test_round_robin();
        tick();
        rd_req = 2'b11; arready = 1; rd_addr = {32'hB000_0040, 32'hA000_0010};
        #2;
        n_vec++; if ({arvalid, arid} !== {1'b1, 4'd0}) begin n_err++; $display("FAIL rr_c0_arid: got %b/%0d want 1/0", arvalid, arid); end
        n_vec++; if (rd_addr_ok !== 2'b01) begin n_err++; $display("FAIL rr_c0_ok: got %b want 01", rd_addr_ok); end
        n_vec++; if ({arsize, arburst, arlock, arcache, arprot} !== {3'd2, 2'd1, 2'd0, 4'd0, 3'd0}) begin n_err++; $display("FAIL rr_attrs: got %h want 2/1/0", {arsize, arburst, arlock, arcache, arprot}); end
        tick();
        rd_req = 2'b10;
        #2;
        n_vec++; if ({arid, araddr} !== {4'd1, 32'hB000_0040}) begin n_err++; $display("FAIL rr_c1_arid: got %0d/%h want 1/b0000040", arid, araddr); end
        n_vec++; if (rd_addr_ok !== 2'b10) begin n_err++; $display("FAIL rr_c1_ok: got %b want 10", rd_addr_ok); end
        tick(); idle_inputs();
        #2;
        n_vec++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL rr_c2_idle: got %b want 0", arvalid); end
        send_rlast(4'd0, 2'b01);
        send_rlast(4'd1, 2'b10);
    endtask

    task automatic test_ar_hold();
        logic [31:0] beat_dat;
        tick();
        rd_req = 2'b10; rd_addr[63:32] = 32'h1000; rd_len[7:4] = 4'd3; arready = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            if (i == 1) begin rd_req = 2'b11; rd_addr[63:32] = 32'h5555; rd_len[3:0] = 4'd1; end
            arready = (i == 3);
            #2;
            n_vec++; if ({arvalid, arid, araddr, arlen} !== {1'b1, 4'd1, 32'h1000, 4'd3}) begin n_err++; $display("FAIL hold_payload c%0d: got %b/%0d/%h/%0d want 1/1/1000/3", i, arvalid, arid, araddr, arlen); end
            n_vec++; if (rd_addr_ok !== ((i == 3) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL hold_ok c%0d: got %b", i, rd_addr_ok); end
        end
        tick(); idle_inputs();
        for (int b = 0; b < 4; b++) begin
            if (b > 0) tick();
            beat_dat = $urandom;
            rvalid = 1; rid = 4'd1; rlast = (b == 3); rdata = beat_dat; rresp = 2'd0;
            #2;
            n_vec++; if ({rd_valid, rd_data} !== {2'b10, beat_dat}) begin n_err++; $display("FAIL hold_beat%0d: got %b/%h want 10/%h", b, rd_valid, rd_data, beat_dat); end
            n_vec++; if (rd_last !== ((b == 3) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL hold_last%0d: got %b", b, rd_last); end
        end
        tick(); idle_inputs();
    endtask

    task automatic test_outstanding();
        tick();
        rd_req = 2'b01; rd_addr[31:0] = 32'h100; arready = 1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #2;
            n_vec++; if (rd_addr_ok !== ((i < 4) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL outst_issue%0d: got %b", i, rd_addr_ok); end
        end
        n_vec++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL outst_blocked: got %b want 0", arvalid); end
        tick();
        rvalid = 1; rid = 4'd0; rlast = 1;
        #2;
        n_vec++; if ({arvalid, rd_valid} !== {1'b0, 2'b01}) begin n_err++; $display("FAIL outst_rlast_cycle: got %b/%b want 0/01", arvalid, rd_valid); end
        tick();
        rvalid = 0; rlast = 0;
        #2;
        n_vec++; if ({arvalid, rd_addr_ok} !== {1'b1, 2'b01}) begin n_err++; $display("FAIL outst_after: got %b/%b want 1/01", arvalid, rd_addr_ok); end
        tick(); idle_inputs();
        for (int i = 0; i < 4; i++) send_rlast(4'd0, 2'b01);
        tick(); idle_inputs();
    endtask

    task automatic test_write();
        tick();
        wr_req = 1; wr_addr = 32'h2000; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
        #2;
        n_vec++; if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {2'b11, 32'h2000, 32'hDEADBEEF, 4'hF}) begin n_err++; $display("FAIL wr_launch: got %b%b/%h/%h/%h", awvalid, wvalid, awaddr, wdata, wstrb); end
        n_vec++; if ({awid, wid, awlen, awsize, wlast} !== {4'd1, 4'd1, 4'd0, 3'd2, 1'b1}) begin n_err++; $display("FAIL wr_attrs: got %0d/%0d/%0d/%0d/%b", awid, wid, awlen, awsize, wlast); end
        n_vec++; if (wr_addr_ok !== 1'b0) begin n_err++; $display("FAIL wr_ok_c0: got %b want 0", wr_addr_ok); end
        tick();
        wr_req = 0; awready = 1;
        #2;
        n_vec++; if ({awvalid, awaddr, wr_addr_ok} !== {1'b1, 32'h2000, 1'b0}) begin n_err++; $display("FAIL wr_c1: got %b/%h/%b", awvalid, awaddr, wr_addr_ok); end
        tick();
        awready = 0; wr_req = 1; wr_data = 32'h1234_5678;
        #2;
        n_vec++; if ({awvalid, wvalid, wdata, wr_addr_ok} !== {2'b01, 32'hDEADBEEF, 1'b0}) begin n_err++; $display("FAIL wr_c2: got %b%b/%h/%b", awvalid, wvalid, wdata, wr_addr_ok); end
        tick();
        wr_req = 0; wready = 1;
        #2;
        n_vec++; if (wr_addr_ok !== 1'b1) begin n_err++; $display("FAIL wr_c3_ok: got %b want 1", wr_addr_ok); end
        tick();
        wready = 0;
        #2;
        n_vec++; if ({awvalid, wvalid, wr_addr_ok} !== 3'b000) begin n_err++; $display("FAIL wr_c4_idle: got %b", {awvalid, wvalid, wr_addr_ok}); end
        tick();
        bvalid = 1; bid = 4'd1; bresp = 2'd2;
        #2;
        n_vec++; if ({wr_ok, wr_err} !== 2'b11) begin n_err++; $display("FAIL wr_bresp: got %b want 11", {wr_ok, wr_err}); end
        tick(); idle_inputs();
    endtask

    task automatic test_write_limit();
        tick();
        wr_req = 1; awready = 1; wready = 1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            wr_addr = 32'h3000 + i * 4;
            #2;
            n_vec++; if ({awvalid, wr_addr_ok} !== ((i < 4) ? 2'b11 : 2'b00)) begin n_err++; $display("FAIL wlim%0d: got %b", i, {awvalid, wr_addr_ok}); end
        end
        tick(); idle_inputs();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            bvalid = 1; bid = 4'd1; bresp = 2'd0;
            #2;
            n_vec++; if ({wr_ok, wr_err} !== 2'b10) begin n_err++; $display("FAIL wlim_b%0d: got %b want 10", i, {wr_ok, wr_err}); end
        end
        tick(); idle_inputs();
    endtask

    task automatic test_unexpected();
        do_reset();
        rvalid = 1; rid = 4'd0; rlast = 1;
        #2;
        n_vec++; if ({rd_valid, err_unexp} !== 3'b000) begin n_err++; $display("FAIL unexp_zero_cnt: got %b want 000", {rd_valid, err_unexp}); end
        tick(); idle_inputs();
        #2;
        n_vec++; if (err_unexp !== 1'b1) begin n_err++; $display("FAIL unexp_sticky0: got %b want 1", err_unexp); end
        do_reset();
        rvalid = 1; rid = 4'd3; rlast = 1;
        #2;
        n_vec++; if (rd_valid !== 2'b00) begin n_err++; $display("FAIL unexp_rid3: got %b want 00", rd_valid); end
        tick(); idle_inputs();
        tick();
        n_vec++; if (err_unexp !== 1'b1) begin n_err++; $display("FAIL unexp_sticky3: got %b want 1", err_unexp); end
        do_reset();
    endtask

    task automatic test_reset_hold();
        tick();
        rd_req = 2'b10; arready = 1;
        tick();
        arready = 0;
        tick();
        #2;
        n_vec++; if ({arvalid, arid} !== {1'b1, 4'd1}) begin n_err++; $display("FAIL rh_hold: got %b/%0d want 1/1", arvalid, arid); end
        areset = 1;
        #2;
        n_vec++; if (arvalid !== 1'b0) begin n_err++; $display("FAIL rh_arvalid: got %b want 0", arvalid); end
        tick();
        areset = 0; rd_req = 2'b11; arready = 1;
        #2;
        n_vec++; if ({arid, rd_addr_ok} !== {4'd0, 2'b01}) begin n_err++; $display("FAIL rh_first_grant: got %0d/%b want 0/01", arid, rd_addr_ok); end
        tick(); idle_inputs();
        rvalid = 1; rid = 4'd1; rlast = 1;
        #2;
        n_vec++; if (rd_valid !== 2'b00) begin n_err++; $display("FAIL rh_stale_resp: got %b want 00", rd_valid); end
        do_reset();
    endtask

    task automatic test_random();
        bit act [NPORT];
        logic [31:0] m_addr [NPORT];
        logic [3:0] m_len [NPORT];
        int outst [NPORT];
        int q_id [$];
        int q_len [$];
        int rr, held, beat, exp_p, pc;
        bit rv, rl;
        logic [31:0] rd_dat;
        logic [1:0] rr_resp, exp_v;
        rr = 0; held = -1; beat = 0;
        for (int p = 0; p < NPORT; p++) begin act[p] = 0; outst[p] = 0; m_addr[p] = '0; m_len[p] = '0; end
        for (int cyc = 0; cyc < 2500; cyc++) begin
            tick(); idle_inputs();
            for (int p = 0; p < NPORT; p++) begin
                if (!act[p] && cyc < 2000 && $urandom_range(0, 2) == 0) begin
                    act[p] = 1; m_addr[p] = $urandom; m_len[p] = 4'($urandom_range(0, MAX_LEN - 1));
                end
                rd_req[p] = act[p];
                rd_addr[p*32 +: 32] = m_addr[p];
                rd_len[p*4 +: 4] = m_len[p];
            end
            arready = 1'($urandom_range(0, 1));
            rv = (q_id.size() > 0) && ($urandom_range(0, 3) != 0);
            rl = 0; rd_dat = $urandom; rr_resp = 2'($urandom_range(0, 3));
            if (rv) begin
                rl = (beat == q_len[0]);
                rvalid = 1; rid = 4'(q_id[0]); rlast = rl; rdata = rd_dat; rresp = rr_resp;
            end
            exp_p = held;
            if (held < 0) begin
                for (int k = 0; k < NPORT; k++) begin
                    pc = (rr + k) % NPORT;
                    if (exp_p < 0 && act[pc] && outst[pc] < MAX_OUTST) exp_p = pc;
                end
            end
            #2;
            n_vec++; if (arvalid !== (exp_p >= 0)) begin n_err++; $display("FAIL rnd_arvalid cyc%0d: got %b want %0d", cyc, arvalid, exp_p >= 0); end
            if (exp_p >= 0) begin
                n_vec++; if ({arid, araddr, arlen} !== {4'(exp_p), m_addr[exp_p], m_len[exp_p]}) begin n_err++; $display("FAIL rnd_ar cyc%0d: got %0d/%h/%0d want %0d/%h/%0d", cyc, arid, araddr, arlen, exp_p, m_addr[exp_p], m_len[exp_p]); end
            end
            exp_v = (exp_p >= 0 && arready) ? 2'(1 << exp_p) : 2'b00;
            n_vec++; if (rd_addr_ok !== exp_v) begin n_err++; $display("FAIL rnd_ok cyc%0d: got %b want %b", cyc, rd_addr_ok, exp_v); end
            exp_v = rv ? 2'(1 << q_id[0]) : 2'b00;
            n_vec++; if (rd_valid !== exp_v) begin n_err++; $display("FAIL rnd_rd_valid cyc%0d: got %b want %b", cyc, rd_valid, exp_v); end
            if (rv) begin
                n_vec++; if ({rd_data, rd_last, rd_err} !== {rd_dat, rl ? exp_v : 2'b00, (rr_resp != 0) ? exp_v : 2'b00}) begin n_err++; $display("FAIL rnd_beat cyc%0d: got %h/%b/%b", cyc, rd_data, rd_last, rd_err); end
            end
            if (exp_p >= 0) begin
                if (arready) begin
                    outst[exp_p]++; q_id.push_back(exp_p); q_len.push_back(int'(m_len[exp_p]));
                    act[exp_p] = 0; rr = (exp_p + 1) % NPORT; held = -1;
                end else begin
                    held = exp_p;
                end
            end
            if (rv) begin
                if (rl) begin
                    outst[q_id[0]]--; void'(q_id.pop_front()); void'(q_len.pop_front()); beat = 0;
                end else begin
                    beat++;
                end
            end
        end
        n_vec++; if (q_id.size() != 0 || act[0] || act[1]) begin n_err++; $display("FAIL rnd_drain_timeout: %0d bursts left, want 0", q_id.size()); end
        tick(); idle_inputs();
        #2;
        n_vec++; if (err_unexp !== 1'b0) begin n_err++; $display("FAIL rnd_err_unexp: got %b want 0", err_unexp); end
    endtask

    initial begin
        areset = 0;
        idle_inputs();
        #1 areset = 1;
        test_reset();
        test_round_robin();
        test_ar_hold();
        test_outstanding();
        test_write();
        test_write_limit();
        test_unexpected();
        test_reset_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
